// File: rtl/rmp_stp.sv
// rmp_stp: programmable stepped-staircase generator for fast-DAC carry and step-linearity checks.
// Produces bipolar, unipolar, sawtooth or static staircases with a saturated, registered output.
module rmp_stp #(
    parameter int unsigned W  = 16,
    parameter int unsigned KW = 4,
    parameter int unsigned DW = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [31:0]          N,
    input  logic signed [W-1:0]  step,
    input  logic signed [W-1:0]  offset,
    input  logic [KW-1:0]        k_max,
    input  logic [DW-1:0]        n_hold,
    input  logic [DW-1:0]        n_ramp,
    input  logic [DW-1:0]        n_peak,
    input  logic [1:0]           mode,
    input  logic                 oneshot,
    input  logic                 trig,
    output logic signed [W-1:0]  out,
    output logic                 sync,
    output logic                 done
);

    // Level needs one extra bit over W+KW so the negated peak never wraps; the sum one more.
    localparam int unsigned LW = W + KW + 1;
    localparam int unsigned SW = W + KW + 2;

    localparam logic signed [SW-1:0] SatHi = {{(SW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [SW-1:0] SatLo = {{(SW - W + 1){1'b1}}, {(W - 1){1'b0}}};

    localparam logic [1:0] ModeBipolar = 2'd0;
    localparam logic [1:0] ModeSaw     = 2'd2;
    localparam logic [1:0] ModeStatic  = 2'd3;

    typedef enum logic [2:0] {
        StHold,
        StUp,
        StPeak,
        StDown,
        StIdle
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 tick;
    logic [DW-1:0]        dwell_q, dwell_d;
    logic [DW-1:0]        n_cur, last_cur;
    logic [KW-1:0]        idx_q, idx_d;
    logic                 pol_q, pol_d;     // 1 = negative half
    logic signed [W-1:0]  step_q, step_d;
    logic [KW-1:0]        kmax_q, kmax_d;
    logic [1:0]           mode_q, mode_d;
    logic                 sync_q, sync_d;
    logic                 done_q, done_d;
    logic signed [LW-1:0] level_q, level_d;
    logic signed [W-1:0]  out_q, out_d;

    logic                 to_hold;
    logic                 pol_new;
    logic                 flat;

    logic signed [LW-1:0] step_x, idx_x, mag;
    logic signed [SW-1:0] sum;

    // Prescaler: one tick every N enabled cycles (N of 0 or 1 ticks every enabled cycle).
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (en) begin
            if ((N > 32'd1) && (cnt_q < (N - 32'd1))) begin
                cnt_d = cnt_q + 32'd1;
            end else begin
                cnt_d = '0;
                tick  = 1'b1;
            end
        end
    end

    // Dwell target for the current state; a programmed 0 behaves like 1.
    always_comb begin
        case (state_q)
            StUp, StDown: n_cur = n_ramp;
            StPeak:       n_cur = n_peak;
            default:      n_cur = n_hold;
        endcase
        last_cur = (n_cur == '0) ? '0 : (n_cur - DW'(1));
    end

    // Staircase sequencer: next state, index, polarity, parameter latching and sync.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        idx_d   = idx_q;
        pol_d   = pol_q;
        step_d  = step_q;
        kmax_d  = kmax_q;
        mode_d  = mode_q;
        sync_d  = 1'b0;
        to_hold = 1'b0;
        pol_new = pol_q;
        flat    = (kmax_q == '0) || (mode_q == ModeStatic);

        if (state_q == StIdle) begin
            // Trigger restarts immediately; free-running mode waits for a tick.
            if (trig || (!oneshot && tick)) begin
                state_d = StHold;
                dwell_d = '0;
                idx_d   = '0;
                pol_d   = 1'b0;
                step_d  = step;
                kmax_d  = k_max;
                mode_d  = mode;
                sync_d  = 1'b1;
            end
        end else if (tick) begin
            // Compare with < so a live dwell shortened below the count still moves on.
            if (dwell_q < last_cur) begin
                dwell_d = dwell_q + DW'(1);
            end else begin
                dwell_d = '0;
                case (state_q)
                    StHold: begin
                        if (flat) begin
                            to_hold = 1'b1;
                        end else if (kmax_q == KW'(1)) begin
                            state_d = StPeak;
                            idx_d   = kmax_q;
                        end else begin
                            state_d = StUp;
                            idx_d   = KW'(1);
                        end
                    end
                    StUp: begin
                        if (idx_q < (kmax_q - KW'(1))) begin
                            idx_d = idx_q + KW'(1);
                        end else begin
                            state_d = StPeak;
                            idx_d   = kmax_q;
                        end
                    end
                    StPeak: begin
                        if ((kmax_q > KW'(1)) && (mode_q != ModeSaw)) begin
                            state_d = StDown;
                            idx_d   = kmax_q - KW'(1);
                        end else begin
                            to_hold = 1'b1;
                            pol_new = (mode_q == ModeBipolar) ? ~pol_q : 1'b0;
                        end
                    end
                    StDown: begin
                        if (idx_q > KW'(1)) begin
                            idx_d = idx_q - KW'(1);
                        end else begin
                            to_hold = 1'b1;
                            pol_new = (mode_q == ModeBipolar) ? ~pol_q : 1'b0;
                        end
                    end
                    default: ;
                endcase

                if (to_hold) begin
                    state_d = StHold;
                    idx_d   = '0;
                    pol_d   = pol_new;
                    // Returning to HOLD on the positive side closes a period.
                    if (!pol_new) begin
                        step_d = step;
                        kmax_d = k_max;
                        mode_d = mode;
                        sync_d = 1'b1;
                        if (oneshot) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
        end

        done_d = (state_d == StIdle);
    end

    // Level for the upcoming state: signed index times the latched step.
    always_comb begin
        step_x  = {{(LW - W){step_d[W-1]}}, step_d};
        idx_x   = {{(LW - KW){1'b0}}, idx_d};
        mag     = step_x * idx_x;
        level_d = pol_d ? -mag : mag;
    end

    // Offset plus level, clamped to the W-bit signed range.
    always_comb begin
        sum = {{(SW - W){offset[W-1]}}, offset} + {{(SW - LW){level_q[LW-1]}}, level_q};
        if (sum > SatHi) begin
            out_d = {1'b0, {(W - 1){1'b1}}};
        end else if (sum < SatLo) begin
            out_d = {1'b1, {(W - 1){1'b0}}};
        end else begin
            out_d = sum[W-1:0];
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Sequencer state, latched parameters and level register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHold;
            dwell_q <= '0;
            idx_q   <= '0;
            pol_q   <= 1'b0;
            step_q  <= step;
            kmax_q  <= k_max;
            mode_q  <= mode;
            level_q <= '0;
            sync_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            pol_q   <= pol_d;
            step_q  <= step_d;
            kmax_q  <= kmax_d;
            mode_q  <= mode_d;
            level_q <= level_d;
            sync_q  <= sync_d;
            done_q  <= done_d;
        end
    end

    // Output register; keeps following offset even while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out  = out_q;
    assign sync = sync_q;
    assign done = done_q;

endmodule

// File: tb/tb_rmp_stp.sv
// tb_rmp_stp: directed plus randomized checks of rmp_stp against a per-period level-list model.
module tb_rmp_stp;

    localparam int W  = 16;
    localparam int KW = 4;
    localparam int DW = 6;
    localparam longint SatHi = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SatLo = -(longint'(1) <<< (W - 1));

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [31:0]         N;
    logic signed [W-1:0] step;
    logic signed [W-1:0] offset;
    logic [KW-1:0]       k_max;
    logic [DW-1:0]       n_hold;
    logic [DW-1:0]       n_ramp;
    logic [DW-1:0]       n_peak;
    logic [1:0]          mode;
    logic                oneshot;
    logic                trig;
    logic signed [W-1:0] out;
    logic                sync;
    logic                done;

    rmp_stp #(.W(W), .KW(KW), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .N       (N),
        .step    (step),
        .offset  (offset),
        .k_max   (k_max),
        .n_hold  (n_hold),
        .n_ramp  (n_ramp),
        .n_peak  (n_peak),
        .mode    (mode),
        .oneshot (oneshot),
        .trig    (trig),
        .out     (out),
        .sync    (sync),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the remaining per-tick levels of the current period.
    longint          lvl_q[$];
    longint          m_lvl;
    longint          m_out;
    bit              m_sync;
    bit              m_done;
    bit              m_idle;
    longint unsigned m_cnt;

    int     sync_cnt;
    longint out_max;
    longint out_min;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint eff(input logic [DW-1:0] n);
        return (n == '0) ? 1 : longint'(n);
    endfunction

    function automatic longint sat(input longint v);
        if (v > SatHi) return SatHi;
        if (v < SatLo) return SatLo;
        return v;
    endfunction

    task automatic push_n(input longint v, input longint cnt);
        for (longint i = 0; i < cnt; i++) lvl_q.push_back(v);
    endtask

    // Lay out one whole period from the current inputs, one entry per tick.
    task automatic build_period();
        longint k;
        longint s;
        longint sg;
        int     halves;
        k = longint'(k_max);
        s = longint'(step);
        lvl_q.delete();
        if (k == 0 || mode == 2'd3) begin
            push_n(0, eff(n_hold));
        end else begin
            halves = (mode == 2'd0) ? 2 : 1;
            for (int h = 0; h < halves; h++) begin
                sg = (h == 0) ? 1 : -1;
                push_n(0, eff(n_hold));
                for (longint i = 1; i < k; i++) push_n(sg * i * s, eff(n_ramp));
                push_n(sg * k * s, eff(n_peak));
                if (mode != 2'd2) begin
                    for (longint i = k - 1; i >= 1; i--) push_n(sg * i * s, eff(n_ramp));
                end
            end
        end
    endtask

    task automatic start_period();
        build_period();
        m_lvl  = lvl_q.pop_front();
        m_sync = 1'b1;
        m_done = 1'b0;
        m_idle = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_edge();
        bit tick;
        tick = 1'b0;
        if (rst) begin
            m_cnt = 0;
            m_out = 0;
            build_period();
            m_lvl  = lvl_q.pop_front();
            m_sync = 1'b0;
            m_done = 1'b0;
            m_idle = 1'b0;
            return;
        end
        m_out  = sat(longint'(offset) + m_lvl);
        m_sync = 1'b0;
        if (en) begin
            if (N > 1 && m_cnt < longint'(N) - 1) m_cnt++;
            else begin
                m_cnt = 0;
                tick  = 1'b1;
            end
        end
        if (m_idle) begin
            if (trig || (!oneshot && tick)) start_period();
        end else if (tick) begin
            if (lvl_q.size() > 0) begin
                m_lvl = lvl_q.pop_front();
            end else if (oneshot) begin
                m_lvl  = 0;
                m_idle = 1'b1;
                m_done = 1'b1;
                m_sync = 1'b1;
            end else begin
                start_period();
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("out", out, m_out);
        check("sync", sync, m_sync);
        check("done", done, m_done);
        if (sync === 1'b1) sync_cnt++;
        if (!$isunknown(out)) begin
            if (longint'(out) > out_max) out_max = longint'(out);
            if (longint'(out) < out_min) out_min = longint'(out);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sync_cnt = 0;
        out_max  = SatLo;
        out_min  = SatHi;
    endtask

    task automatic set_cfg(input int n, input int k, input int h, input int r, input int p,
                           input int s, input int o, input int md);
        N      = 32'(n);
        k_max  = KW'(k);
        n_hold = DW'(h);
        n_ramp = DW'(r);
        n_peak = DW'(p);
        step   = W'(s);
        offset = W'(o);
        mode   = 2'(md);
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        oneshot = 1'b0;
        trig    = 1'b0;
        set_cfg(1, 2, 8, 10, 2, 100, 0, 0);

        // Bipolar 60-cycle period.
        do_reset();
        repeat (130) cyc();
        check("bip_syncs", sync_cnt, 2);
        check("bip_peak", out_max, 200);
        check("bip_trough", out_min, -200);

        // Prescaled sawtooth with an enable gap.
        set_cfg(4, 3, 1, 1, 1, 10, 0, 2);
        do_reset();
        repeat (37) cyc();
        en = 1'b0;
        repeat (7) cyc();
        en = 1'b1;
        repeat (40) cyc();
        check("saw_top", out_max, 30);

        // Saturation high, then low in the negative half.
        set_cfg(1, 3, 1, 1, 1, 20000, 'h7000, 1);
        do_reset();
        repeat (20) cyc();
        check("sat_hi", out_max, 32767);
        set_cfg(1, 3, 1, 1, 1, 20000, -'h7000, 0);
        do_reset();
        repeat (30) cyc();
        check("sat_lo", out_min, -32768);

        // One-shot then trigger.
        set_cfg(1, 2, 2, 2, 2, 100, 55, 1);
        oneshot = 1'b1;
        do_reset();
        repeat (40) cyc();
        check("os_done", done, 1);
        check("os_out", out, 55);
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        check("trig_sync", sync, 1);
        check("trig_done", done, 0);
        repeat (30) cyc();
        oneshot = 1'b0;

        // Mid-period parameter changes take effect next period; K=0 is flat.
        set_cfg(1, 2, 3, 3, 3, 100, 0, 1);
        do_reset();
        repeat (5) cyc();
        step  = W'(50);
        k_max = KW'(4);
        repeat (60) cyc();
        k_max = '0;
        offset = W'(-321);
        repeat (40) cyc();
        check("k0_out", out, -321);

        // Reset while at the peak.
        set_cfg(1, 2, 8, 10, 2, 100, 0, 0);
        do_reset();
        repeat (19) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_out", out, 0);
        repeat (60) cyc();

        // Randomized rounds.
        for (int r = 0; r < 12; r++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 4), int'($urandom),
                    int'($urandom), $urandom_range(0, 3));
            oneshot = ($urandom_range(0, 3) == 0);
            en      = 1'b1;
            trig    = 1'b0;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                en   = ($urandom_range(0, 9) != 0);
                trig = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0) offset = W'($urandom);
                if ($urandom_range(0, 49) == 0) begin
                    step  = W'($urandom);
                    k_max = KW'($urandom_range(0, 6));
                    mode  = 2'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 29) == 0) N = 32'($urandom_range(0, 3));
                if ($urandom_range(0, 79) == 0) oneshot = ~oneshot;
                rst = ($urandom_range(0, 199) == 0);
                cyc();
            end
            rst  = 1'b0;
            trig = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rmp_stp.md
Name: rmp_stp

Overview:
- Parametrised stepped-staircase generator for checking fast-DAC carry transitions and step linearity.
- Produces programmable staircases: bipolar, unipolar, sawtooth or static.
- Level count, per-level dwell, tick prescale and offset are all programmable; a one-shot/trigger mode is included.
- Drives a fast-DAC data path; `sync` marks period start for scope triggering.

Parameters:
- W, 16: output/step/offset width, signed.
- KW, 4: width of `k_max`; peak multiple is up to 2^KW-1.
- DW, 6: width of the dwell-count inputs.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  run enable; low freezes prescaler and FSM.
- N  in  32  tick period in clk cycles; 0 and 1 both mean every cycle.
- step  in  W  signed step size.
- offset  in  W  signed offset added to level.
- k_max  in  KW  peak multiple K.
- n_hold  in  DW  ticks held at level 0.
- n_ramp  in  DW  ticks per interior level.
- n_peak  in  DW  ticks at peak level.
- mode  in  2  0 bipolar, 1 unipolar, 2 sawtooth, 3 static.
- oneshot  in  1  stop after one period.
- trig  in  1  restart from IDLE.
- out  out  W  signed registered output.
- sync  out  1  one-cycle period-start pulse.
- done  out  1  high in IDLE.

Behaviour:
- Reset values: prescaler=0, dwell=0, idx=0, pol=+, state=HOLD, level=0, out=0, sync=0, done=0. `step`, `k_max` and `mode` are latched during reset.
- Prescaler: while `en`=1, if cnt<N-1 then cnt++, else cnt=0 and tick=1. With N≤1, tick=1 every `en` cycle.
- FSM advances only on tick. A dwell value of 0 is treated as 1.
- Each state holds until dwell reaches (its n_x)-1; the next tick then moves on and clears dwell.
- States:
  - HOLD: idx=0.
  - UP: idx 1..K-1, each held n_ramp ticks.
  - PEAK: idx=K, held n_peak ticks.
  - DOWN: idx K-1..1, each held n_ramp ticks.
  - IDLE: idx=0.
- Transitions:
  - HOLD→UP when K≥2; HOLD→PEAK when K=1.
  - PEAK→DOWN when K≥2 and mode≠2; PEAK→HOLD otherwise.
  - DOWN at idx 1 → HOLD.
- Polarity (on entering HOLD from DOWN or PEAK):
  - Mode 0: pol toggles.
  - Modes 1 and 2: pol stays +.
- Period end is entry into HOLD with pol=+ (mode 0: after the negative half).
- At period end:
  - `step`, `k_max` and `mode` are re-latched. Dwells, `N` and `offset` stay live.
  - sync=1 for exactly that one clk.
  - If `oneshot`=1, go to IDLE instead, with done=1.
- K=0 or mode 3: FSM stays in HOLD, level=0, out=offset. sync pulses every n_hold ticks.
- IDLE behaviour:
  - `trig`=1 → period start (HOLD, pol=+, latch, sync pulse, done=0) on the next clk, without waiting for a tick.
  - `oneshot`=0 → leave IDLE on the next tick the same way.
  - `trig` is ignored outside IDLE.
- Level arithmetic: level = (pol ? -1 : +1) · idx · step_latched, computed at W+KW+1 bits and registered on the state update.
- Output:
  - out <= sat_W(offset + level), computed at W+KW+2 bits and clamped to [-2^(W-1), 2^(W-1)-1].
  - `out` lags the level register by 1 clk.
  - An `offset` change appears at `out` 1 clk later, regardless of `en` or tick.
- `en`=0 mid-dwell: state, dwell and prescaler hold; the sequence resumes exactly on re-enable.
- `rst` mid-operation: all state returns to the reset values on that clk; `out`=0 on the next clk.

Test Plan:
- Bipolar: N=1, K=2, n_hold=8, n_ramp=10, n_peak=2, step=100, offset=0, mode 0 → `out` repeats 0×8, 100×10, 200×2, 100×10, 0×8, -100×10, -200×2, -100×10 (60-cycle period). `sync` pulses once per 60 cycles.
- Prescale and sawtooth: N=4, K=3, n_hold=1, n_ramp=1, n_peak=1, step=10, mode 2 → 0,10,20,30 repeating, each value held 4 clks. Toggling `en` low for 7 clks stretches only the current value by 7.
- Saturation: W=16, step=20000, K=3, offset=0x7000, mode 1 → peak `out`=32767. With pol − in mode 0 and offset=-0x7000, peak `out`=-32768.
- One-shot: oneshot=1, mode 1, K=2 → after one period `out`=offset and done=1 indefinitely. A 1-clk `trig` gives sync next clk, done=0, and the sequence restarts.
- Latch timing: change step 100→50 and K 2→4 mid-period → the current period completes unchanged; the next period uses the new values. K=0 → out=offset constant.
- Reset mid-PEAK: assert `rst` 1 clk → `out`=0, sync=0, done=0 next clk. The sequence then restarts from HOLD with pol=+.
